brisc_fetch_buffer: RTL
=======================

Name: brisc_fetch_buffer

Overview:
Parametrised front-end fetch unit: PC generator, plus an in-order instruction queue of DEPTH entries between the instruction cache and decode.
Issues sequential fetch requests from a boot vector and tracks outstanding responses.
Redirects to a branch target or to the exception vector, discarding stale in-flight responses.
Presents a NOP to decode whenever no valid instruction is available.

Parameters:
ILEN, 32, instruction width in bits
ADDR_W, 32, PC/address width in bits
DEPTH, 4, queue entries; power of two, >= 2; also caps outstanding cache requests
PC_BOOT, 32'h00001000, PC loaded at reset
PC_EXCEPT, 32'h00002000, PC loaded on exception
NOP_INSTR, 32'h00000013, instruction driven to decode when not valid (ADDI x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid_o  out  1  fetch request valid
req_addr_o  out  ADDR_W  fetch address
req_ready_i  in  1  cache accepts request
resp_valid_i  in  1  in-order cache response valid (always accepted)
resp_instr_i  in  ILEN  response instruction
dec_valid_o  out  1  head entry valid for decode
dec_instr_o  out  ILEN  head instruction, NOP_INSTR when dec_valid_o=0
dec_pc_o  out  ADDR_W  head PC, 0 when dec_valid_o=0
dec_ready_i  in  1  decode consumes head
redirect_i  in  1  branch/jump taken
redirect_pc_i  in  ADDR_W  redirect target
except_i  in  1  exception; priority over redirect_i

Behaviour:
- Reset (async assert, sync release): pc_q=PC_BOOT; head/alloc/fill pointers=0; all filled bits=0; drop_cnt=0.
- Outputs during reset: req_valid_o=0, dec_valid_o=0, dec_instr_o=NOP_INSTR, dec_pc_o=0.
- Entry state: each entry holds pc, instr and a filled bit.
  - alloc_cnt = alloc-head (0..DEPTH).
  - unfilled = alloc-fill.
  - Pointer width is clog2(DEPTH)+1 so full and empty are distinguishable.
- Request:
  - req_valid_o = !flush && (alloc_cnt + drop_cnt) < DEPTH, where flush = except_i | redirect_i.
  - req_addr_o = pc_q.
  - On req_valid_o & req_ready_i: entry[alloc].pc<=pc_q, alloc++, pc_q<=pc_q+4. The add wraps modulo 2^ADDR_W.
  - req_valid_o and req_addr_o may drop without handshake only on flush.
- Response (same cycle as resp_valid_i):
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Else: entry[fill].instr<=resp_instr_i, filled<=1, fill++.
  - A response with no outstanding request is illegal; flag it with an assertion.
- Decode: dec_valid_o = filled[head], combinational from registers; dec_instr_o/dec_pc_o from entry[head].
  - On dec_valid_o & dec_ready_i: filled[head]<=0, head++.
  - A response can fill an entry that is being requested in the same cycle, or that was empty.
  - It cannot make dec_valid_o high in the same cycle; minimum latency from response to dec_valid_o is 1 cycle.
- Throughput: request accept, response fill and decode pop may occur in one cycle, giving a sustained 1 instr/cycle.
- Flush (except_i or redirect_i high at a clock edge):
  - pc_q <= PC_EXCEPT if except_i, else {redirect_pc_i[ADDR_W-1:2],2'b00}.
  - head/alloc/fill<=0; all filled<=0.
  - drop_cnt <= drop_cnt + unfilled - (resp_valid_i ? 1 : 0). The response in the flush cycle is discarded.
  - The decode pop in the flush cycle is ignored. No request is issued in the flush cycle.
  - The first new request can be issued the cycle after the flush.
- Flush with an empty queue and nothing outstanding: only pc_q changes.
- Back-to-back flushes: each recomputes drop_cnt; the last target wins.
- Invariant: drop_cnt + alloc_cnt <= DEPTH at all times; assert it.

Test Plan:
- Reset release, req_ready_i=1, 1-cycle response latency, dec_ready_i=1:
  - req_addr_o = 0x1000, 0x1004, 0x1008 on consecutive cycles.
  - dec_pc_o = 0x1000 with the matching instruction 2 cycles after the first request.
  - One instruction per cycle after that, no bubbles.
- dec_ready_i=0, responses keep arriving:
  - After 4 accepts, req_valid_o=0 and dec_valid_o=1 holding 0x1000.
  - Raise dec_ready_i for one cycle: exactly one new request, addr 0x1010.
- 3 requests outstanding, no responses, redirect_i=1 with redirect_pc_i=0x4006:
  - Next cycle drop_cnt=3 and req_addr_o=0x4004.
  - The next 3 responses are discarded, never reaching decode.
  - The 4th response appears as dec_pc_o=0x4004.
- except_i and redirect_i together (redirect_pc_i=0x5000), with a response arriving that cycle:
  - pc_q=0x2000.
  - The simultaneous response is dropped and drop_cnt excludes it.
- Queue empty, no requests accepted: dec_valid_o=0, dec_instr_o=0x00000013, dec_pc_o=0.
- rst_n asserted mid-stream with 2 valid and 2 outstanding entries:
  - Outputs return to reset values immediately (asynchronously).
  - After release, the first req_addr_o=0x1000 and drop_cnt=0.

Source files
------------

// File: rtl/brisc_fetch_buffer_if.sv
// Fetch-unit bus bundle: cache request/response, decode handshake and redirect controls.
// master is the fetch unit; slave is the surrounding cache/decode environment.
interface brisc_fetch_buffer_if #(
    parameter int unsigned ILEN   = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              req_valid_o;
    logic [ADDR_W-1:0] req_addr_o;
    logic              req_ready_i;
    logic              resp_valid_i;
    logic [ILEN-1:0]   resp_instr_i;
    logic              dec_valid_o;
    logic [ILEN-1:0]   dec_instr_o;
    logic [ADDR_W-1:0] dec_pc_o;
    logic              dec_ready_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              except_i;

    modport master (
        output req_valid_o, req_addr_o, dec_valid_o, dec_instr_o, dec_pc_o,
        input  req_ready_i, resp_valid_i, resp_instr_i, dec_ready_i,
        input  redirect_i, redirect_pc_i, except_i
    );

    modport slave (
        input  req_valid_o, req_addr_o, dec_valid_o, dec_instr_o, dec_pc_o,
        output req_ready_i, resp_valid_i, resp_instr_i, dec_ready_i,
        output redirect_i, redirect_pc_i, except_i
    );
endinterface

// File: rtl/brisc_fetch_buffer.sv
// Front-end fetch unit: sequential PC generator feeding an in-order instruction queue
// between the instruction cache and decode, with branch/exception redirect.
module brisc_fetch_buffer #(
    parameter int unsigned       ILEN      = 32,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DEPTH     = 4,
    parameter logic [ADDR_W-1:0] PC_BOOT   = 32'h0000_1000,
    parameter logic [ADDR_W-1:0] PC_EXCEPT = 32'h0000_2000,
    parameter logic [ILEN-1:0]   NOP_INSTR = 32'h0000_0013
) (
    input logic                  clk,
    input logic                  rst_n,
    brisc_fetch_buffer_if.master bus
);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(DEPTH);

    logic [ADDR_W-1:0] pc_q;
    logic [PW-1:0]     head_q, alloc_q, fill_q, drop_cnt_q;
    logic [DEPTH-1:0]  filled_q;
    logic [ADDR_W-1:0] entry_pc_q    [DEPTH];
    logic [ILEN-1:0]   entry_instr_q [DEPTH];

    logic          flush, req_valid, req_fire, resp_fill, dec_valid, dec_fire;
    logic [PW-1:0] alloc_cnt, unfilled;
    logic [PW:0]   in_use;
    logic [IW-1:0] head_idx, alloc_idx, fill_idx;

    assign flush     = bus.except_i | bus.redirect_i;
    assign alloc_cnt = alloc_q - head_q;
    assign unfilled  = alloc_q - fill_q;
    // Stale in-flight responses still occupy cache slots, so they count against DEPTH.
    assign in_use    = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};
    assign head_idx  = head_q[IW-1:0];
    assign alloc_idx = alloc_q[IW-1:0];
    assign fill_idx  = fill_q[IW-1:0];

    assign req_valid = rst_n & ~flush & (in_use < DEPTH_CNT);
    assign req_fire  = req_valid & bus.req_ready_i;
    assign resp_fill = bus.resp_valid_i & ~flush & (drop_cnt_q == '0);
    assign dec_valid = filled_q[head_idx];
    assign dec_fire  = dec_valid & bus.dec_ready_i & ~flush;

    assign bus.req_valid_o = req_valid;
    assign bus.req_addr_o  = pc_q;
    assign bus.dec_valid_o = dec_valid;
    assign bus.dec_instr_o = dec_valid ? entry_instr_q[head_idx] : NOP_INSTR;
    assign bus.dec_pc_o    = dec_valid ? entry_pc_q[head_idx] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= PC_BOOT;
            head_q     <= '0;
            alloc_q    <= '0;
            fill_q     <= '0;
            drop_cnt_q <= '0;
            filled_q   <= '0;
        end else if (flush) begin
            pc_q       <= bus.except_i ? PC_EXCEPT : {bus.redirect_pc_i[ADDR_W-1:2], 2'b00};
            head_q     <= '0;
            alloc_q    <= '0;
            fill_q     <= '0;
            filled_q   <= '0;
            // Every unfilled slot becomes a stale response; one arriving now is already gone.
            drop_cnt_q <= drop_cnt_q + unfilled - PW'(bus.resp_valid_i);
        end else begin
            if (req_fire) begin
                pc_q    <= pc_q + ADDR_W'(4);
                alloc_q <= alloc_q + PW'(1);
            end
            if (bus.resp_valid_i && drop_cnt_q != '0) begin
                drop_cnt_q <= drop_cnt_q - PW'(1);
            end
            if (resp_fill) begin
                filled_q[fill_idx] <= 1'b1;
                fill_q             <= fill_q + PW'(1);
            end
            if (dec_fire) begin
                filled_q[head_idx] <= 1'b0;
                head_q             <= head_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            entry_pc_q[alloc_idx] <= pc_q;
        end
        if (resp_fill) begin
            entry_instr_q[fill_idx] <= bus.resp_instr_i;
        end
    end

    // A response must belong to a stale or a live outstanding request.
    assert property (@(posedge clk) disable iff (!rst_n)
        bus.resp_valid_i |-> (drop_cnt_q != '0 || unfilled != '0 || req_fire));

    assert property (@(posedge clk) disable iff (!rst_n) in_use <= DEPTH_CNT);
endmodule
